// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types: the common data bus word and CDB arbiter sizing.
package lc3b_types;

   localparam int cdb_num_src    = 4;
   localparam int cdb_fifo_depth = 2;
   localparam int cdb_tag_width  = 3;
   localparam int cdb_data_width = 16;

   typedef struct packed {
      logic                      valid;
      logic [cdb_tag_width-1:0]  tag;
      logic [cdb_data_width-1:0] data;
   } CDB;

endpackage

// File: rtl/cdb_src_fifo.sv
// Per-source result FIFO: power-of-two depth, occupancy counter for full/empty,
// synchronous flush. Push while full and pop while empty are ignored.
module cdb_src_fifo #(
   parameter int W     = 19,
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         flush,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
   logic [PW-1:0]           wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic                    do_push, do_pop;

   assign full  = (cnt_q == CW'(DEPTH));
   assign empty = (cnt_q == '0);
   assign dout  = mem_q[rd_q];

   always_comb begin
      mem_d   = mem_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      do_push = push & ~full;
      do_pop  = pop & ~empty;
      if (do_push) begin
         mem_d[wr_q] = din;
         wr_d        = wr_q + PW'(1);
      end
      if (do_pop) rd_d = rd_q + PW'(1);
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
   end

   always_ff @(posedge clk) begin
      if (flush) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   // Storage needs no reset; the counter alone decides what is valid.
   always_ff @(posedge clk) mem_q <= mem_d;

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-source FIFOs, round-robin select of one head per
// cycle, registered CDB broadcast.
module cdb_arbiter
   import lc3b_types::*;
#(
   parameter int NUM_SRC    = cdb_num_src,
   parameter int DEPTH      = cdb_fifo_depth,
   parameter int data_width = cdb_data_width,
   parameter int tag_width  = cdb_tag_width
) (
   input  logic               clk,
   input  logic               flush,
   input  CDB                 src_in [NUM_SRC],
   output logic [NUM_SRC-1:0] src_ack,
   output CDB                 CDB_out,
   output logic [NUM_SRC-1:0] fifo_full
);

   localparam int W    = tag_width + data_width;
   localparam int RR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

   logic [NUM_SRC-1:0]        empty, pop;
   logic [NUM_SRC-1:0][W-1:0] head;
   logic                      found;
   logic [RR_W-1:0]           win, rr_q, rr_d;
   int                        idx;
   CDB                        cdb_q, cdb_d;

   for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
      // No pass-through: a full FIFO refuses even if it is popped this cycle.
      assign src_ack[g] = src_in[g].valid & ~fifo_full[g] & ~flush;

      cdb_src_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
         .clk   (clk),
         .flush (flush),
         .push  (src_ack[g]),
         .pop   (pop[g]),
         .din   ({src_in[g].tag, src_in[g].data}),
         .dout  (head[g]),
         .full  (fifo_full[g]),
         .empty (empty[g])
      );
   end

   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = 0;
      pop   = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         idx = (int'(rr_q) + k) % NUM_SRC;
         if (!found && !empty[idx]) begin
            found = 1'b1;
            win   = RR_W'(idx);
         end
      end
      rr_d        = rr_q;
      cdb_d       = cdb_q;
      cdb_d.valid = 1'b0;
      if (found) begin
         pop[win] = 1'b1;
         rr_d     = (int'(win) == NUM_SRC - 1) ? '0 : win + RR_W'(1);
         cdb_d    = {1'b1, head[win]};
      end
   end

   always_ff @(posedge clk) begin
      if (flush) begin
         rr_q  <= '0;
         cdb_q <= '0;
      end else begin
         rr_q  <= rr_d;
         cdb_q <= cdb_d;
      end
   end

   assign CDB_out = cdb_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: hand-derived vector table, corner sequences and random
// traffic against a queue-based reference model.
module tb_cdb_arbiter;
   import lc3b_types::*;

   localparam int N = 4;
   localparam int D = 2;

   logic           clk;
   logic           flush;
   CDB             src_in [N];
   logic [N-1:0]   src_ack;
   CDB             CDB_out;
   logic [N-1:0]   fifo_full;

   cdb_arbiter #(.NUM_SRC(N), .DEPTH(D), .data_width(16), .tag_width(3)) dut (
      .clk       (clk),
      .flush     (flush),
      .src_in    (src_in),
      .src_ack   (src_ack),
      .CDB_out   (CDB_out),
      .fifo_full (fifo_full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic [N-1:0]        drv_v;
   logic [N-1:0][2:0]   drv_tag;
   logic [N-1:0][15:0]  drv_data;
   logic [N-1:0]        obs_ack, obs_full;

   // reference model: one queue per source plus round-robin pointer
   logic [18:0] mq [N][$];
   int          m_rr;
   CDB          m_cdb;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic step(input logic fl);
      logic [N-1:0] e_ack, e_full;
      int w;
      flush = fl;
      for (int i = 0; i < N; i++) src_in[i] = '{drv_v[i], drv_tag[i], drv_data[i]};
      #1;
      for (int i = 0; i < N; i++) begin
         e_ack[i]  = drv_v[i] && (mq[i].size() < D) && !fl;
         e_full[i] = (mq[i].size() == D);
      end
      obs_ack  = src_ack;
      obs_full = fifo_full;
      check("model_ack", 32'(src_ack), 32'(e_ack));
      check("model_full", 32'(fifo_full), 32'(e_full));
      @(posedge clk);
      if (fl) begin
         for (int i = 0; i < N; i++) mq[i].delete();
         m_rr  = 0;
         m_cdb = '0;
      end else begin
         w = -1;
         for (int k = 0; k < N; k++)
            if (w < 0 && mq[(m_rr + k) % N].size() > 0) w = (m_rr + k) % N;
         if (w >= 0) begin
            m_cdb = {1'b1, mq[w].pop_front()};
            m_rr  = (w + 1) % N;
         end else begin
            m_cdb.valid = 1'b0;
         end
         for (int i = 0; i < N; i++)
            if (e_ack[i]) mq[i].push_back({drv_tag[i], drv_data[i]});
      end
      #1;
      check("model_cdb", 32'(CDB_out), 32'(m_cdb));
      @(negedge clk);
   endtask

   typedef struct {
      logic        fl;
      logic [3:0]  v;
      logic [11:0] tags;
      logic [63:0] datas;
      logic [3:0]  e_ack;
      logic        e_cv;
      logic [2:0]  e_tag;
      logic [15:0] e_data;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic fl, logic [3:0] v, logic [11:0] t, logic [63:0] d,
                               logic [3:0] a, logic cv, logic [2:0] ct, logic [15:0] cd);
      vec_t r;
      r.fl = fl; r.v = v; r.tags = t; r.datas = d;
      r.e_ack = a; r.e_cv = cv; r.e_tag = ct; r.e_data = cd;
      return r;
   endfunction

   int n3;
   bit seen_full;

   initial begin
      flush = 1'b1;
      drv_v = '0; drv_tag = '0; drv_data = '0;
      for (int i = 0; i < N; i++) src_in[i] = '0;
      m_rr = 0; m_cdb = '0;
      @(posedge clk);
      @(negedge clk);

      // reset
      vecs.push_back(mk(1, 4'b0000, 12'd0, 64'd0, 4'b0000, 0, 3'd0, 16'h0000));
      vecs.push_back(mk(1, 4'b0000, 12'd0, 64'd0, 4'b0000, 0, 3'd0, 16'h0000));
      // single source, two-cycle latency, one-cycle valid
      vecs.push_back(mk(0, 4'b0001, {9'd0, 3'd3}, {48'd0, 16'h1234}, 4'b0001, 0, 3'd0, 16'h0000));
      vecs.push_back(mk(0, 4'b0000, 12'd0, 64'd0, 4'b0000, 1, 3'd3, 16'h1234));
      vecs.push_back(mk(0, 4'b0000, 12'd0, 64'd0, 4'b0000, 0, 3'd3, 16'h1234));
      vecs.push_back(mk(1, 4'b0000, 12'd0, 64'd0, 4'b0000, 0, 3'd0, 16'h0000));
      // all four at once, served in order
      vecs.push_back(mk(0, 4'b1111, {3'd3, 3'd2, 3'd1, 3'd0}, {16'hA3, 16'hA2, 16'hA1, 16'hA0},
                        4'b1111, 0, 3'd0, 16'h0000));
      vecs.push_back(mk(0, 4'b0000, 12'd0, 64'd0, 4'b0000, 1, 3'd0, 16'h00A0));
      vecs.push_back(mk(0, 4'b0000, 12'd0, 64'd0, 4'b0000, 1, 3'd1, 16'h00A1));
      vecs.push_back(mk(0, 4'b0000, 12'd0, 64'd0, 4'b0000, 1, 3'd2, 16'h00A2));
      vecs.push_back(mk(0, 4'b0000, 12'd0, 64'd0, 4'b0000, 1, 3'd3, 16'h00A3));
      vecs.push_back(mk(0, 4'b0000, 12'd0, 64'd0, 4'b0000, 0, 3'd3, 16'h00A3));
      // idle hold of tag/data
      vecs.push_back(mk(0, 4'b0010, {6'd0, 3'd5, 3'd0}, {32'd0, 16'hBEEF, 16'd0}, 4'b0010, 0, 3'd3, 16'h00A3));
      vecs.push_back(mk(0, 4'b0000, 12'd0, 64'd0, 4'b0000, 1, 3'd5, 16'hBEEF));
      vecs.push_back(mk(0, 4'b0000, 12'd0, 64'd0, 4'b0000, 0, 3'd5, 16'hBEEF));
      // fairness: src1 streams, src2 one result
      vecs.push_back(mk(1, 4'b0000, 12'd0, 64'd0, 4'b0000, 0, 3'd0, 16'h0000));
      vecs.push_back(mk(0, 4'b0110, {3'd0, 3'd2, 3'd1, 3'd0}, {16'h0, 16'h0022, 16'h0011, 16'h0},
                        4'b0110, 0, 3'd0, 16'h0000));
      vecs.push_back(mk(0, 4'b0010, {6'd0, 3'd1, 3'd0}, {32'd0, 16'h0012, 16'd0}, 4'b0010, 1, 3'd1, 16'h0011));
      vecs.push_back(mk(0, 4'b0010, {6'd0, 3'd1, 3'd0}, {32'd0, 16'h0013, 16'd0}, 4'b0010, 1, 3'd2, 16'h0022));
      vecs.push_back(mk(0, 4'b0010, {6'd0, 3'd1, 3'd0}, {32'd0, 16'h0014, 16'd0}, 4'b0000, 1, 3'd1, 16'h0012));
      vecs.push_back(mk(0, 4'b0010, {6'd0, 3'd1, 3'd0}, {32'd0, 16'h0014, 16'd0}, 4'b0010, 1, 3'd1, 16'h0013));
      vecs.push_back(mk(0, 4'b0000, 12'd0, 64'd0, 4'b0000, 1, 3'd1, 16'h0014));
      vecs.push_back(mk(0, 4'b0000, 12'd0, 64'd0, 4'b0000, 0, 3'd1, 16'h0014));

      foreach (vecs[r]) begin
         drv_v    = vecs[r].v;
         drv_tag  = vecs[r].tags;
         drv_data = vecs[r].datas;
         step(vecs[r].fl);
         check($sformatf("vec%0d_ack", r), 32'(obs_ack), 32'(vecs[r].e_ack));
         check($sformatf("vec%0d_cdb", r), 32'(CDB_out),
               32'({vecs[r].e_cv, vecs[r].e_tag, vecs[r].e_data}));
      end

      // back-pressure: everyone streams, count src3 acks before it first reports full
      drv_v = '0;
      step(1'b1);
      n3 = 0; seen_full = 0;
      for (int i = 0; i < N; i++) begin
         drv_tag[i]  = 3'(i);
         drv_data[i] = 16'(i * 16'h1000);
      end
      drv_v = '1;
      for (int c = 0; c < 16; c++) begin
         step(1'b0);
         if (!seen_full) begin
            if (obs_full[3]) seen_full = 1;
            else if (obs_ack[3]) n3++;
         end
         for (int i = 0; i < N; i++) if (obs_ack[i]) drv_data[i] = drv_data[i] + 16'd1;
      end
      check("src3_acks_before_full", 32'(n3), 32'd2);
      check("src3_full_seen", 32'(seen_full), 32'd1);

      // flush mid-stream with every source still presenting
      step(1'b1);
      check("flush_ack", 32'(obs_ack), 32'd0);
      check("flush_cdb_valid", 32'(CDB_out.valid), 32'd0);
      step(1'b0);
      check("post_flush_full", 32'(obs_full), 32'd0);
      drv_v = '0;
      step(1'b0);
      check("post_flush_first", 32'({CDB_out.valid, CDB_out.tag}), 32'({1'b1, 3'd0}));

      // random traffic honouring the hold-until-ack rule
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!(drv_v[i] && !obs_ack[i])) begin
               drv_v[i]    = 1'($urandom_range(0, 1));
               drv_tag[i]  = 3'($urandom_range(0, 7));
               drv_data[i] = 16'($urandom);
            end
         end
         step($urandom_range(0, 39) == 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
